// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio output mixer.
// Saturation behaviour is selected with MIXER_SATURATE_EN.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MIX   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } mix_state_t;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    function automatic int calc_div(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/sample_pacer.sv
// Free-running sample-rate divider: one-cycle tick every CLK_HZ/SAMPLE_HZ clocks.
module sample_pacer
    import audio_mix_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int SAMPLE_HZ = 48000
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)            cnt <= '0;
        else if (cnt == LAST)  cnt <= '0;
        else                   cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/audio_out_mixer.sv
// Mixes two signed sources into the codec stream at the paced sample rate.
// Define MIXER_SATURATE_EN to clamp the sum instead of wrapping it.
module audio_out_mixer
    import audio_mix_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int SAMPLE_HZ = 48000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] met_sound,
    input  logic        met_valid,
    input  logic [31:0] tone_sound,
    input  logic        tone_valid,
    input  logic [1:0]  gain_shift,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [7:0]  overrun_count
);

    mix_state_t         state;
    logic               tick;
    logic [32:0]        sum33;
    logic [31:0]        reduced;
    logic signed [31:0] reduced_s;
    logic [31:0]        mixed;
    logic [31:0]        mix_q;

    sample_pacer #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_pacer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );

    // Sign-extend each source to 33 bits so the sum cannot overflow before reduction.
    always_comb begin
        sum33 = (met_valid  ? {met_sound[31],  met_sound}  : 33'd0)
              + (tone_valid ? {tone_sound[31], tone_sound} : 33'd0);
`ifdef MIXER_SATURATE_EN
        if (sum33[32] != sum33[31])
            reduced = sum33[32] ? SAT_MIN : SAT_MAX;
        else
            reduced = sum33[31:0];
`else
        reduced = sum33[31:0];
`endif
        reduced_s = $signed(reduced);
        mixed     = 32'(reduced_s >>> gain_shift);
    end

`ifndef MIXER_SATURATE_EN
    logic unused_sum_msb;
    assign unused_sum_msb = sum33[32];
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            write_audio_out <= 1'b0;
            mix_q           <= '0;
            overrun_count   <= '0;
        end else begin
            // Any tick outside IDLE is a dropped sample.
            if (tick && state != ST_IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;

            case (state)
                ST_IDLE: begin
                    write_audio_out <= 1'b0;
                    if (tick && (met_valid || tone_valid))
                        state <= ST_MIX;
                end
                ST_MIX: begin
                    mix_q <= mixed;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (audio_out_allowed) begin
                        state           <= ST_WRITE;
                        write_audio_out <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    write_audio_out <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    write_audio_out <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

    assign left_channel_audio_out  = mix_q;
    assign right_channel_audio_out = mix_q;

endmodule

// File: tb/tb_audio_out_mixer.sv
// Directed bench for audio_out_mixer at default rates (divider 1041).
// Compile with MIXER_SATURATE_EN to exercise the clamping build.
module tb_audio_out_mixer;

    logic        CLOCK_50;
    logic        reset;
    logic [31:0] met_sound;
    logic        met_valid;
    logic [31:0] tone_sound;
    logic        tone_valid;
    logic [1:0]  gain_shift;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [7:0]  overrun_count;

    int checks   = 0;
    int failures = 0;

    audio_out_mixer dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .met_sound               (met_sound),
        .met_valid               (met_valid),
        .tone_sound              (tone_sound),
        .tone_valid              (tone_valid),
        .gain_shift              (gain_shift),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .overrun_count           (overrun_count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Counts negedges until write_audio_out is seen; 0 means the bound expired.
    task automatic wait_write(input int bound, output int cycles);
        cycles = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        met_sound = 0; met_valid = 0; tone_sound = 0; tone_valid = 0;
        gain_shift = 0; audio_out_allowed = 1;
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (write_audio_out !== 1'b0) begin
            failures++; $display("FAIL reset_write got=%0b exp=0", write_audio_out);
        end
        checks++;
        if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
            failures++; $display("FAIL reset_channels got=%0h/%0h exp=0",
                                 left_channel_audio_out, right_channel_audio_out);
        end
        checks++;
        if (overrun_count !== 8'd0) begin
            failures++; $display("FAIL reset_overrun got=%0d exp=0", overrun_count);
        end
        reset = 1'b1;
    endtask

    // Tick is at count 1040 after release; write lands 3 clocks later, on edge 1043.
    task automatic test_basic();
        int c;
        met_sound = 32'd300000000; met_valid = 1; tone_valid = 0;
        gain_shift = 0; audio_out_allowed = 1;
        wait_write(1200, c);
        checks++;
        if (c != 1043) begin
            failures++; $display("FAIL basic_latency got=%0d exp=1043", c);
        end
        checks++;
        if (left_channel_audio_out !== 32'd300000000 || right_channel_audio_out !== 32'd300000000) begin
            failures++; $display("FAIL basic_value got=%0d/%0d exp=300000000",
                                 left_channel_audio_out, right_channel_audio_out);
        end
        @(negedge CLOCK_50);
        checks++;
        if (write_audio_out !== 1'b0) begin
            failures++; $display("FAIL basic_pulse_width got=%0b exp=0", write_audio_out);
        end
        wait_write(1200, c);
        checks++;
        if (c != 1040) begin
            failures++; $display("FAIL basic_period got=%0d exp=1041", c + 1);
        end
    endtask

    task automatic test_sum();
        int c;
        logic [31:0] exp;
`ifdef MIXER_SATURATE_EN
        exp = 32'h7FFF_FFFF;
`else
        exp = 32'hEE6B_2800;   // -294967296
`endif
        met_sound = 32'd2000000000; met_valid = 1;
        tone_sound = 32'd2000000000; tone_valid = 1;
        wait_write(1200, c);
        checks++;
        if (c == 0 || left_channel_audio_out !== exp || right_channel_audio_out !== exp) begin
            failures++; $display("FAIL sum_overflow got=%0h/%0h exp=%0h waited=%0d",
                                 left_channel_audio_out, right_channel_audio_out, exp, c);
        end
        met_sound = 32'h8000_0000; tone_sound = 32'hFFFF_FFFF;
`ifdef MIXER_SATURATE_EN
        exp = 32'h8000_0000;
`else
        exp = 32'h7FFF_FFFF;
`endif
        wait_write(1200, c);
        checks++;
        if (c == 0 || left_channel_audio_out !== exp) begin
            failures++; $display("FAIL sum_underflow got=%0h exp=%0h waited=%0d",
                                 left_channel_audio_out, exp, c);
        end
    endtask

    task automatic test_gain();
        int c;
        met_sound = -32'sd300000000; met_valid = 1; tone_valid = 0;
        tone_sound = 32'd12345; gain_shift = 2;
        wait_write(1200, c);
        checks++;
        if (c == 0 || left_channel_audio_out !== 32'(-75000000)) begin
            failures++; $display("FAIL gain_shift2 got=%0d exp=-75000000 waited=%0d",
                                 $signed(left_channel_audio_out), c);
        end
        met_sound = 32'd100; tone_sound = 32'd20; tone_valid = 1; gain_shift = 3;
        wait_write(1200, c);
        checks++;
        if (c == 0 || right_channel_audio_out !== 32'd15) begin
            failures++; $display("FAIL gain_shift3 got=%0d exp=15 waited=%0d",
                                 right_channel_audio_out, c);
        end
        gain_shift = 0;
    endtask

    // Starts right after a write; ticks follow at +1038, +2079, +3120 from here.
    task automatic test_overrun();
        int writes = 0;
        int c;
        met_sound = 32'd111; met_valid = 1; tone_valid = 0; gain_shift = 0;
        audio_out_allowed = 0;
        for (int i = 0; i < 3540; i++) begin
            @(negedge CLOCK_50);
            if (i == 1100) met_sound = 32'd222;
            if (write_audio_out === 1'b1) writes++;
        end
        checks++;
        if (writes != 0) begin
            failures++; $display("FAIL overrun_no_write got=%0d exp=0", writes);
        end
        checks++;
        if (overrun_count !== 8'd2) begin
            failures++; $display("FAIL overrun_count got=%0d exp=2", overrun_count);
        end
        checks++;
        if (left_channel_audio_out !== 32'd111 || right_channel_audio_out !== 32'd111) begin
            failures++; $display("FAIL overrun_hold got=%0d/%0d exp=111",
                                 left_channel_audio_out, right_channel_audio_out);
        end
        audio_out_allowed = 1;
        wait_write(5, c);
        checks++;
        if (c == 0 || left_channel_audio_out !== 32'd111) begin
            failures++; $display("FAIL overrun_release got=%0d exp=111 waited=%0d",
                                 left_channel_audio_out, c);
        end
    endtask

    task automatic test_idle();
        int writes = 0;
        do_reset();
        met_valid = 0; tone_valid = 0; audio_out_allowed = 1;
        for (int i = 0; i < 3 * 1041 + 20; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) writes++;
        end
        checks++;
        if (writes != 0) begin
            failures++; $display("FAIL idle_no_write got=%0d exp=0", writes);
        end
        checks++;
        if (overrun_count !== 8'd0) begin
            failures++; $display("FAIL idle_overrun got=%0d exp=0", overrun_count);
        end
    endtask

    task automatic test_reset_wait();
        int c;
        int writes = 0;
        do_reset();
        met_sound = 32'd5; met_valid = 1; tone_valid = 0; gain_shift = 0;
        audio_out_allowed = 0;
        repeat (1045) @(negedge CLOCK_50);
        checks++;
        if (left_channel_audio_out !== 32'd5) begin
            failures++; $display("FAIL rstwait_mixed got=%0d exp=5", left_channel_audio_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0 ||
            write_audio_out !== 1'b0 || overrun_count !== 8'd0) begin
            failures++; $display("FAIL rstwait_async got=%0h/%0h/%0b/%0d exp=0",
                                 left_channel_audio_out, right_channel_audio_out,
                                 write_audio_out, overrun_count);
        end
        audio_out_allowed = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) writes++;
        end
        reset = 1'b1;
        checks++;
        if (writes != 0) begin
            failures++; $display("FAIL rstwait_no_strobe got=%0d exp=0", writes);
        end
        wait_write(1200, c);
        checks++;
        if (c != 1043 || left_channel_audio_out !== 32'd5) begin
            failures++; $display("FAIL rstwait_resume got=%0d/%0d exp=1043/5",
                                 c, left_channel_audio_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sum();
        test_gain();
        test_overrun();
        test_idle();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_out_mixer.md
AUDIO_OUT_MIXER -- requirements
Module: audio_out_mixer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the CLOCK_50 frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_HZ, default 48000, meaning the output sample rate in Hz.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port met_sound, input, 32 bits: signed metronome sample.
REQ-006 SHALL have port met_valid, input, 1 bit: metronome sample valid (level, metronome's write request).
REQ-007 SHALL have port tone_sound, input, 32 bits: signed second-source sample.
REQ-008 SHALL have port tone_valid, input, 1 bit: second-source sample valid (level).
REQ-009 SHALL have port gain_shift, input, 2 bits: attenuation as an arithmetic right shift of 0..3.
REQ-010 SHALL have port audio_out_allowed, input, 1 bit: codec FIFO has space.
REQ-011 SHALL have port write_audio_out, output, 1 bit: one-cycle write strobe to the codec.
REQ-012 SHALL have port left_channel_audio_out, output, 32 bits: mixed sample.
REQ-013 SHALL have port right_channel_audio_out, output, 32 bits: mixed sample, always equal to left.
REQ-014 SHALL have port overrun_count, output, 8 bits: count of dropped sample ticks.

Function
REQ-015 SHALL derive DIV = CLK_HZ/SAMPLE_HZ with integer division (1041 at defaults); the pacer counts 0..DIV-1 and asserts tick for one cycle at count DIV-1, then wraps to 0.
REQ-016 SHALL implement FSM states IDLE, MIX, WAIT, WRITE.
REQ-017 IDLE: on tick with met_valid|tone_valid = 1, go to MIX; on tick with both valids low, stay in IDLE with no write.
REQ-018 MIX: register sum = (met_valid ? met_sound : 0) + (tone_valid ? tone_sound : 0), computed 33-bit signed, reduced to 32 bits per REQ-026/027, then arithmetic-shifted right by gain_shift; drive the result on both channels; go to WAIT.
REQ-019 Inputs SHALL be sampled in the MIX cycle only, not in the tick cycle.
REQ-020 WAIT: if audio_out_allowed = 1, go to WRITE; otherwise hold, with channel outputs unchanged.
REQ-021 WRITE: write_audio_out = 1 for exactly this cycle (Moore output), then go to IDLE.
REQ-022 Latency: tick in cycle N with audio_out_allowed high SHALL give write_audio_out in cycle N+3.
REQ-023 A tick arriving in MIX, WAIT or WRITE SHALL be dropped (held sample not replaced) and SHALL increment overrun_count, saturating at 255.
REQ-024 Channel outputs SHALL change only in the MIX cycle and SHALL be stable during WAIT and WRITE.

Reset
REQ-025 reset = 0 SHALL asynchronously set: state IDLE, pacer count 0, write_audio_out 0, both channels 0, overrun_count 0. Reset during WAIT/WRITE aborts the pending write with no strobe.

Configuration
REQ-026 With MIXER_SATURATE_EN defined, the 33-bit sum SHALL clamp to 32'h7FFFFFFF / 32'h80000000 before the shift.
REQ-027 Without MIXER_SATURATE_EN, the sum SHALL be truncated to its low 32 bits (two's-complement wrap).

Structure
REQ-028 Package audio_mix_pkg SHALL hold the FSM state typedef, the SAT_MAX/SAT_MIN constants, and the DIV computation function.
REQ-029 Sub-module sample_pacer SHALL contain the tick counter (parameters CLK_HZ, SAMPLE_HZ; output tick).

Verification
REQ-030 met 300000000 valid, tone invalid, gain 0, allowed high -> channels 300000000; write pulse 3 cycles after tick; next write 1041 cycles later.
REQ-031 met 2000000000 and tone 2000000000, both valid -> 0x7FFFFFFF with MIXER_SATURATE_EN; -294967296 without.
REQ-032 met -300000000 valid, gain_shift 2 -> channels -75000000.
REQ-033 allowed held low for 2500 cycles after a tick -> exactly 2 overruns counted, one write after allowed rises, channels unchanged meanwhile.
REQ-034 Both valids low across 3 ticks -> no write_audio_out, overrun_count stays 0.
REQ-035 reset asserted in WAIT -> no write pulse, all outputs 0; normal write at the first tick after release.
